// File: rtl/clock_pkg.sv
// Constants and helpers shared by the blocks in the system clock domain.
package clock_pkg;

  localparam int CLK_FREQ_HZ_DEFAULT = 12_000_000;

  // Bits needed to hold 0 .. modulus-1, never fewer than one.
  function automatic int count_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Free-running modulo counter: counts 0 .. MODULUS-1 and flags the last value.
module mod_counter
  import clock_pkg::*;
#(
  parameter int MODULUS = 2
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  output logic [count_width(MODULUS)-1:0]  count,
  output logic                             wrap
);

  localparam int           W    = count_width(MODULUS);
  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  logic [W-1:0] r_count;

  // Count register; wrapping on LAST keeps it strictly below MODULUS.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= {W{1'b0}};
    end else if (wrap) begin
      r_count <= {W{1'b0}};
    end else begin
      r_count <= r_count + W'(1'b1);
    end
  end

  assign count = r_count;
  assign wrap  = (r_count == LAST);

endmodule

// File: rtl/one_hertz_gen.sv
// Square-wave generator: divides i_clk down to OUT_FREQ_HZ with 50% duty,
// toggling a single output register each time the half-period counter wraps.
module one_hertz_gen
  import clock_pkg::*;
#(
  parameter int CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT,
  parameter int OUT_FREQ_HZ = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_signal
);

  localparam int HALF_PERIOD = (OUT_FREQ_HZ >= 1) ? CLK_FREQ_HZ / (2 * OUT_FREQ_HZ) : 0;
  // Clamped so the counter still elaborates while the checks below report the error.
  localparam int MODULUS     = (HALF_PERIOD >= 1) ? HALF_PERIOD : 1;
  localparam int CW          = count_width(MODULUS);

  generate
    if (OUT_FREQ_HZ < 1) begin : g_bad_out_freq
      $fatal(1, "one_hertz_gen: OUT_FREQ_HZ (%0d) must be at least 1", OUT_FREQ_HZ);
    end
    if (HALF_PERIOD < 1) begin : g_bad_half_period
      $fatal(1, "one_hertz_gen: HALF_PERIOD = CLK_FREQ_HZ/(2*OUT_FREQ_HZ) = %0d, must be at least 1",
             HALF_PERIOD);
    end
  endgenerate

  logic [CW-1:0] w_count_unused;
  logic          w_wrap;
  logic          r_signal;

  mod_counter #(
    .MODULUS (MODULUS)
  ) u_counter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .count   (w_count_unused),
    .wrap    (w_wrap)
  );

  // Output level flips only on the wrap edge, so each level lasts HALF_PERIOD clocks.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_signal <= 1'b0;
    end else if (w_wrap) begin
      r_signal <= ~r_signal;
    end else begin
      r_signal <= r_signal;
    end
  end

  assign o_signal = r_signal;

endmodule

// File: tb/tb_one_hertz_gen.sv
// Directed bench for one_hertz_gen at default, small (HALF_PERIOD=6) and
// minimal (HALF_PERIOD=1) parameter sets, each on its own reset.
module tb_one_hertz_gen;

  logic clk = 1'b0;
  always #42 clk = ~clk;

  logic rst_def, rst_small, rst_edge;
  logic sig_def, sig_small, sig_edge;
  int   errors = 0;
  int   checks = 0;

  one_hertz_gen dut_def (
    .i_clk (clk), .i_reset (rst_def), .o_signal (sig_def)
  );

  one_hertz_gen #(.CLK_FREQ_HZ(12), .OUT_FREQ_HZ(1)) dut_small (
    .i_clk (clk), .i_reset (rst_small), .o_signal (sig_small)
  );

  one_hertz_gen #(.CLK_FREQ_HZ(2), .OUT_FREQ_HZ(1)) dut_edge (
    .i_clk (clk), .i_reset (rst_edge), .o_signal (sig_edge)
  );

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      #20;
      checks++;
      if (sig_def !== 1'b0) begin
        errors++; $display("FAIL reset_sig_def: got %b expected 0", sig_def);
      end
      checks++;
      if (dut_def.u_counter.count !== 23'd0) begin
        errors++; $display("FAIL reset_cnt_def: got %0d expected 0", dut_def.u_counter.count);
      end
      checks++;
      if (sig_small !== 1'b0 || dut_small.u_counter.count !== 3'd0) begin
        errors++; $display("FAIL reset_small: got sig=%b cnt=%0d expected sig=0 cnt=0",
                           sig_small, dut_small.u_counter.count);
      end
    end
  endtask

  task automatic test_default_run();
    @(negedge clk);
    rst_def = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_def.u_counter.count !== 23'(k)) begin
        errors++; $display("FAIL default_cnt k=%0d: got %0d expected %0d", k, dut_def.u_counter.count, k);
      end
      checks++;
      if (sig_def !== 1'b0) begin
        errors++; $display("FAIL default_sig k=%0d: got %b expected 0", k, sig_def);
      end
    end
    #10;
    rst_def = 1'b0;
    #1;
    checks++;
    if (sig_def !== 1'b0 || dut_def.u_counter.count !== 23'd0) begin
      errors++; $display("FAIL default_async_reset: got sig=%b cnt=%0d expected sig=0 cnt=0",
                         sig_def, dut_def.u_counter.count);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if (sig_def !== 1'b0 || dut_def.u_counter.count !== 23'd0) begin
        errors++; $display("FAIL default_reset_hold: got sig=%b cnt=%0d expected sig=0 cnt=0",
                           sig_def, dut_def.u_counter.count);
      end
    end
    @(negedge clk);
    rst_def = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_def.u_counter.count !== 23'(k)) begin
        errors++; $display("FAIL default_restart k=%0d: got %0d expected %0d", k, dut_def.u_counter.count, k);
      end
    end
  endtask

  task automatic test_small_wave();
    int   rise1, fall1, rise2;
    logic prev;
    rise1 = 0; fall1 = 0; rise2 = 0;
    prev  = sig_small;
    @(negedge clk);
    rst_small = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      checks++;
      if (sig_small !== 1'((k / 6) % 2)) begin
        errors++; $display("FAIL small_sig k=%0d: got %b expected %0d", k, sig_small, (k / 6) % 2);
      end
      checks++;
      if (dut_small.u_counter.count !== 3'(k % 6)) begin
        errors++; $display("FAIL small_cnt k=%0d: got %0d expected %0d", k, dut_small.u_counter.count, k % 6);
      end
      if (prev === 1'b0 && sig_small === 1'b1) begin
        if (rise1 == 0) rise1 = k; else if (rise2 == 0) rise2 = k;
      end
      if (prev === 1'b1 && sig_small === 1'b0 && fall1 == 0) fall1 = k;
      prev = sig_small;
    end
    checks++;
    if (rise1 != 6) begin errors++; $display("FAIL small_first_rise: got edge %0d expected 6", rise1); end
    checks++;
    if (fall1 != 12) begin errors++; $display("FAIL small_first_fall: got edge %0d expected 12", fall1); end
    checks++;
    if (rise2 != 18) begin errors++; $display("FAIL small_second_rise: got edge %0d expected 18", rise2); end
  endtask

  task automatic test_mid_count_reset();
    @(negedge clk);
    rst_small = 1'b0;
    @(negedge clk);
    rst_small = 1'b1;
    repeat (9) @(posedge clk);
    #10;
    checks++;
    if (sig_small !== 1'b1 || dut_small.u_counter.count !== 3'd3) begin
      errors++; $display("FAIL mid_precondition: got sig=%b cnt=%0d expected sig=1 cnt=3",
                         sig_small, dut_small.u_counter.count);
    end
    rst_small = 1'b0;
    #1;
    checks++;
    if (sig_small !== 1'b0 || dut_small.u_counter.count !== 3'd0) begin
      errors++; $display("FAIL mid_async_clear: got sig=%b cnt=%0d expected sig=0 cnt=0",
                         sig_small, dut_small.u_counter.count);
    end
    @(negedge clk);
    rst_small = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      checks++;
      if (sig_small !== ((k >= 6) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL mid_rerise k=%0d: got %b expected %0d", k, sig_small, (k >= 6) ? 1 : 0);
      end
    end
  endtask

  task automatic test_edge_toggle();
    @(negedge clk);
    rst_edge = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      checks++;
      if (sig_edge !== 1'(k % 2)) begin
        errors++; $display("FAIL edge_toggle k=%0d: got %b expected %0d", k, sig_edge, k % 2);
      end
      checks++;
      if (dut_edge.u_counter.count !== 1'b0) begin
        errors++; $display("FAIL edge_cnt k=%0d: got %0d expected 0", k, dut_edge.u_counter.count);
      end
    end
  endtask

  initial begin
    rst_def   = 1'b0;
    rst_small = 1'b0;
    rst_edge  = 1'b0;
    test_reset();
    test_default_run();
    test_small_wave();
    test_mid_count_reset();
    test_edge_toggle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/one_hertz_gen.md
ONE_HERTZ_GEN -- requirements
Module: one_hertz_gen

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 12_000_000, input clock frequency in Hz.
REQ-002 Parameter OUT_FREQ_HZ, default 1, output square-wave frequency in Hz.
REQ-003 Port i_clk  input  1  sole clock; all state SHALL change on its rising edge, except on asynchronous reset.
REQ-004 Port i_reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port o_signal  output  1  square wave at OUT_FREQ_HZ, 50% duty; driven directly from a register.

Function
REQ-006 Derived constant HALF_PERIOD SHALL equal CLK_FREQ_HZ / (2*OUT_FREQ_HZ), using integer division; the default is 6_000_000.
REQ-007 Elaboration SHALL fail with a clear message if HALF_PERIOD < 1 or OUT_FREQ_HZ < 1.
REQ-008 Counter width SHALL be $clog2(HALF_PERIOD), with a minimum of 1 bit; the default is 23 bits.
REQ-009 The counter SHALL count 0 .. HALF_PERIOD-1, incrementing by 1 on each i_clk rising edge while reset is deasserted.
REQ-010 On a rising edge where the counter equals HALF_PERIOD-1, the counter SHALL wrap to 0 and o_signal SHALL invert, both on that same edge.
REQ-011 o_signal SHALL change only on the wrap edge, so each level lasts exactly HALF_PERIOD clocks and the full period is 2*HALF_PERIOD clocks.
REQ-012 With HALF_PERIOD = 1, o_signal SHALL toggle on every clock edge, giving CLK_FREQ_HZ/2.
REQ-013 The counter SHALL never hold a value >= HALF_PERIOD.
REQ-014 After reset release, the first rising edge of o_signal SHALL occur on the HALF_PERIOD-th i_clk rising edge.
REQ-015 o_signal SHALL be glitch-free: register output only, no combinational path to the port.

Reset
REQ-016 While i_reset = 0, the counter SHALL be 0 and o_signal SHALL be 0, asynchronously and regardless of i_clk.
REQ-017 Reset asserted mid-count or while o_signal = 1 SHALL immediately force both registers to 0; no partial count is retained.
REQ-018 Release SHALL be used directly, with no internal synchronizer; counting starts on the first i_clk rising edge with i_reset = 1.
REQ-019 Reset SHALL be the only way to restart the phase; there is no enable or synchronous clear.

Structure
REQ-020 A package clock_pkg SHALL hold the constant CLK_FREQ_HZ_DEFAULT = 12_000_000 shared with other clock-domain blocks; no typedefs are needed.
REQ-021 A single sub-module mod_counter SHALL provide the wrapping counter, with parameter MODULUS, inputs i_clk and i_reset, and outputs count and wrap (1 when count = MODULUS-1).
REQ-022 The one_hertz_gen top SHALL instantiate mod_counter with MODULUS = HALF_PERIOD and hold only the o_signal toggle register.

Verification
REQ-023 Reset and idle: hold i_reset=0 for 100 ns with a 12 MHz clock -> o_signal=0 and counter=0 throughout.
REQ-024 Short run at default parameters: release reset, run 10 us (~120 clocks), reassert for 100 ns, release -> o_signal stays 0 and counter is 0 during reset, then restarts from 0.
REQ-025 Small parameters (CLK_FREQ_HZ=12, OUT_FREQ_HZ=1, so HALF_PERIOD=6): release reset -> o_signal rises at clock edge 6, falls at 12, rises at 18, giving period 12 clocks and 50% duty.
REQ-026 Mid-count reset (same small parameters): assert i_reset=0 while o_signal=1 at count 3, between clock edges -> o_signal and counter go to 0 without waiting for a clock; after release, the first rise is again at edge 6.
REQ-027 Edge case CLK_FREQ_HZ=2, OUT_FREQ_HZ=1 -> o_signal toggles on every clock edge.
REQ-028 Illegal CLK_FREQ_HZ=1, OUT_FREQ_HZ=1 -> elaboration error.
